// File: rtl/seven_segment_decoder_pkg.sv
// Shared constants for the seven-segment receive-side decoder:
// glyph table, blank pattern, digit enable encodings and FSM states.
package seven_segment_decoder_pkg;

    // Glyphs as active-high gfedcba, before the bus inversion.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // All segments off on the active-low bus.
    localparam logic [6:0] BLANK_PATTERN = 7'h7F;

    // Enables as {led1, led2, led3}, active-low.
    localparam logic [2:0] EN_DIGIT1 = 3'b011;
    localparam logic [2:0] EN_DIGIT2 = 3'b101;
    localparam logic [2:0] EN_DIGIT3 = 3'b110;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational decode of one active-low 7-segment pattern.
// Ports: segments (gfedcba, active-low) in; is_glyph, is_blank, value out.
module seven_segment_pattern_decoder
    import seven_segment_decoder_pkg::*;
(
    input  logic [6:0] segments,
    output logic       is_glyph,
    output logic       is_blank,
    output logic [3:0] value
);

    logic [6:0] lit;

    assign lit = ~segments;

    always_comb begin
        is_glyph = 1'b1;
        is_blank = 1'b0;
        value    = 4'h0;
        unique case (1'b1)
            (lit == GLYPH_0): value = 4'h0;
            (lit == GLYPH_1): value = 4'h1;
            (lit == GLYPH_2): value = 4'h2;
            (lit == GLYPH_3): value = 4'h3;
            (lit == GLYPH_4): value = 4'h4;
            (lit == GLYPH_5): value = 4'h5;
            (lit == GLYPH_6): value = 4'h6;
            (lit == GLYPH_7): value = 4'h7;
            (lit == GLYPH_8): value = 4'h8;
            (lit == GLYPH_9): value = 4'h9;
            (lit == GLYPH_A): value = 4'hA;
            (lit == GLYPH_B): value = 4'hB;
            (lit == GLYPH_C): value = 4'hC;
            (lit == GLYPH_D): value = 4'hD;
            (lit == GLYPH_E): value = 4'hE;
            (lit == GLYPH_F): value = 4'hF;
            (segments == BLANK_PATTERN): begin
                is_glyph = 1'b0;
                is_blank = 1'b1;
            end
            default: is_glyph = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_display_decoder.sv
// Receive-side decoder for a 3-digit multiplexed seven-segment bus.
// Ports: clk, reset_n, display_bits[7:0], led1..3_control_signal in;
//        led1..3_decoded_value[3:0], digit_valid[2:0], pattern_error,
//        frame_done out.
module seven_segment_display_decoder
    import seven_segment_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] display_bits,
    input  logic       led1_control_signal,
    input  logic       led2_control_signal,
    input  logic       led3_control_signal,
    output logic [3:0] led1_decoded_value,
    output logic [3:0] led2_decoded_value,
    output logic [3:0] led3_decoded_value,
    output logic [2:0] digit_valid,
    output logic       pattern_error,
    output logic       frame_done
);

    localparam logic [7:0] CAPTURE_AT = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);

    logic [10:0] sample_d;
    logic [10:0] sample_q;
    logic [7:0]  cnt_q;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [1:0]  mask_q;
    logic        changed;
    logic        onehot_d;
    logic        capture;
    logic        is_glyph;
    logic        is_blank;
    logic [3:0]  dec_value;
    logic [2:0]  en_q;

    assign sample_d = {led1_control_signal, led2_control_signal,
                       led3_control_signal, display_bits};
    assign changed  = (sample_d != sample_q);
    assign onehot_d = (sample_d[10:8] == EN_DIGIT1) ||
                      (sample_d[10:8] == EN_DIGIT2) ||
                      (sample_d[10:8] == EN_DIGIT3);
    assign en_q     = sample_q[10:8];

    // sample_q has been identical for STABLE_CYCLES samples once the
    // counter shows STABLE_CYCLES-1; the capture uses that registered
    // history, so the current input may already be moving on.
    assign capture  = (state_q == SETTLE) && (cnt_q == CAPTURE_AT);

    seven_segment_pattern_decoder u_pattern (
        .segments (sample_q[6:0]),
        .is_glyph (is_glyph),
        .is_blank (is_blank),
        .value    (dec_value)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (onehot_d)
                    state_d = SETTLE;
            end
            SETTLE: begin
                if (!onehot_d)
                    state_d = IDLE;
                else if (capture && !changed)
                    state_d = HOLD;
                else
                    state_d = SETTLE;
            end
            HOLD: begin
                if (changed)
                    state_d = onehot_d ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_q <= {3'b111, 8'hFF};
            cnt_q    <= 8'd0;
            state_q  <= IDLE;
        end else begin
            sample_q <= sample_d;
            state_q  <= state_d;
            if (!onehot_d || changed)
                cnt_q <= 8'd0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led1_decoded_value <= 4'h0;
            led2_decoded_value <= 4'h0;
            led3_decoded_value <= 4'h0;
            digit_valid        <= 3'b000;
            pattern_error      <= 1'b0;
            frame_done         <= 1'b0;
            mask_q             <= 2'b00;
        end else begin
            pattern_error <= 1'b0;
            frame_done    <= 1'b0;
            if (capture) begin
                pattern_error <= !is_glyph && !is_blank;
                unique case (en_q)
                    EN_DIGIT1: begin
                        digit_valid[0] <= is_glyph;
                        mask_q[0]      <= 1'b1;
                        if (is_glyph)
                            led1_decoded_value <= dec_value;
                    end
                    EN_DIGIT2: begin
                        digit_valid[1] <= is_glyph;
                        mask_q[1]      <= 1'b1;
                        if (is_glyph)
                            led2_decoded_value <= dec_value;
                    end
                    EN_DIGIT3: begin
                        // Digit 3 closes a frame whether or not it is
                        // complete; only a complete one is announced.
                        digit_valid[2] <= is_glyph;
                        mask_q         <= 2'b00;
                        frame_done     <= (mask_q == 2'b11);
                        if (is_glyph)
                            led3_decoded_value <= dec_value;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_display_decoder.sv
// Directed self-checking bench for seven_segment_display_decoder.
// Each task drives one scenario and checks its own results.
module tb_seven_segment_display_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] display_bits;
    logic       led1_control_signal;
    logic       led2_control_signal;
    logic       led3_control_signal;
    logic [3:0] led1_decoded_value;
    logic [3:0] led2_decoded_value;
    logic [3:0] led3_decoded_value;
    logic [2:0] digit_valid;
    logic       pattern_error;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_segment_display_decoder #(.STABLE_CYCLES(4)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .display_bits        (display_bits),
        .led1_control_signal (led1_control_signal),
        .led2_control_signal (led2_control_signal),
        .led3_control_signal (led3_control_signal),
        .led1_decoded_value  (led1_decoded_value),
        .led2_decoded_value  (led2_decoded_value),
        .led3_decoded_value  (led3_decoded_value),
        .digit_valid         (digit_valid),
        .pattern_error       (pattern_error),
        .frame_done          (frame_done)
    );

    task automatic drive(input logic [2:0] en, input logic [7:0] bits);
        {led1_control_signal, led2_control_signal,
         led3_control_signal} = en;
        display_bits = bits;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(3'b111, 8'hFF);
        step(2);
        reset_n = 1'b1;
        checks++;
        if ({led1_decoded_value, led2_decoded_value,
             led3_decoded_value} !== 12'h000) begin
            errors++;
            $display("FAIL reset_values got %h exp 000",
                     {led1_decoded_value, led2_decoded_value,
                      led3_decoded_value});
        end
        checks++;
        if (digit_valid !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid got %b exp 000", digit_valid);
        end
        checks++;
        if ({pattern_error, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 00",
                     {pattern_error, frame_done});
        end
    endtask

    task automatic test_digit1;
        drive(3'b011, 8'hC0);
        step(4);
        checks++;
        if (digit_valid !== 3'b000) begin
            errors++;
            $display("FAIL d1_early got %b exp 000", digit_valid);
        end
        step(1);
        checks++;
        if (led1_decoded_value !== 4'h0 || digit_valid !== 3'b001) begin
            errors++;
            $display("FAIL d1_capture got %h/%b exp 0/001",
                     led1_decoded_value, digit_valid);
        end
        checks++;
        if (pattern_error !== 1'b0) begin
            errors++;
            $display("FAIL d1_perr got %b exp 0", pattern_error);
        end
        drive(3'b111, 8'hFF);
        step(2);
    endtask

    task automatic test_glitch;
        drive(3'b101, 8'h80);
        step(3);
        drive(3'b101, 8'hF9);
        step(4);
        checks++;
        if (digit_valid !== 3'b001 || led2_decoded_value !== 4'h0) begin
            errors++;
            $display("FAIL glitch_none got %b/%h exp 001/0",
                     digit_valid, led2_decoded_value);
        end
        step(1);
        checks++;
        if (digit_valid !== 3'b011 || led2_decoded_value !== 4'h1) begin
            errors++;
            $display("FAIL glitch_d2 got %b/%h exp 011/1",
                     digit_valid, led2_decoded_value);
        end
    endtask

    task automatic test_scan;
        logic [2:0] ens [3];
        logic [7:0] pats [3];
        int         fd_cnt [3];
        int         fd_at [3];
        ens  = '{3'b011, 3'b101, 3'b110};
        pats = '{8'hB0, 8'hF8, 8'h88};
        for (int s = 0; s < 3; s++) begin
            fd_cnt[s] = 0;
            fd_at[s]  = -1;
            drive(ens[s], pats[s]);
            for (int c = 1; c <= 10; c++) begin
                step(1);
                if (frame_done === 1'b1) begin
                    fd_cnt[s]++;
                    fd_at[s] = c;
                end
            end
        end
        checks++;
        if ({led1_decoded_value, led2_decoded_value,
             led3_decoded_value} !== 12'h37A) begin
            errors++;
            $display("FAIL scan_values got %h exp 37a",
                     {led1_decoded_value, led2_decoded_value,
                      led3_decoded_value});
        end
        checks++;
        if (digit_valid !== 3'b111) begin
            errors++;
            $display("FAIL scan_valid got %b exp 111", digit_valid);
        end
        checks++;
        if (fd_cnt[0] !== 0 || fd_cnt[1] !== 0 || fd_cnt[2] !== 1) begin
            errors++;
            $display("FAIL scan_fd_count got %0d %0d %0d exp 0 0 1",
                     fd_cnt[0], fd_cnt[1], fd_cnt[2]);
        end
        checks++;
        if (fd_at[2] !== 5) begin
            errors++;
            $display("FAIL scan_fd_cycle got %0d exp 5", fd_at[2]);
        end
    endtask

    task automatic test_bad_pattern;
        int pe_cnt = 0;
        int fd_cnt = 0;
        drive(3'b110, 8'hAA);
        step(4);
        checks++;
        if (pattern_error !== 1'b0) begin
            errors++;
            $display("FAIL perr_early got %b exp 0", pattern_error);
        end
        step(1);
        checks++;
        if (pattern_error !== 1'b1) begin
            errors++;
            $display("FAIL perr_pulse got %b exp 1", pattern_error);
        end
        checks++;
        if (digit_valid !== 3'b011 || led3_decoded_value !== 4'hA) begin
            errors++;
            $display("FAIL perr_state got %b/%h exp 011/a",
                     digit_valid, led3_decoded_value);
        end
        if (frame_done === 1'b1)
            fd_cnt++;
        // Long hold: the pulse must not repeat, so the counter
        // saturates rather than wraps into another capture.
        for (int c = 0; c < 300; c++) begin
            step(1);
            if (pattern_error === 1'b1)
                pe_cnt++;
        end
        checks++;
        if (pe_cnt !== 0) begin
            errors++;
            $display("FAIL perr_hold got %0d exp 0", pe_cnt);
        end
        drive(3'b110, 8'hFF);
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (pattern_error === 1'b1)
                pe_cnt++;
            if (frame_done === 1'b1)
                fd_cnt++;
        end
        checks++;
        if (pe_cnt !== 0 || digit_valid !== 3'b011 ||
            led3_decoded_value !== 4'hA) begin
            errors++;
            $display("FAIL blank got %0d/%b/%h exp 0/011/a",
                     pe_cnt, digit_valid, led3_decoded_value);
        end
        checks++;
        if (fd_cnt !== 0) begin
            errors++;
            $display("FAIL partial_frame_fd got %0d exp 0", fd_cnt);
        end
    endtask

    task automatic test_idle;
        int pulses = 0;
        drive(3'b001, 8'h80);
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (pattern_error === 1'b1 || frame_done === 1'b1)
                pulses++;
        end
        drive(3'b111, 8'hC0);
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (pattern_error === 1'b1 || frame_done === 1'b1)
                pulses++;
        end
        checks++;
        if (pulses !== 0 || digit_valid !== 3'b011 ||
            {led1_decoded_value, led2_decoded_value,
             led3_decoded_value} !== 12'h37A) begin
            errors++;
            $display("FAIL idle got %0d/%b/%h exp 0/011/37a",
                     pulses, digit_valid,
                     {led1_decoded_value, led2_decoded_value,
                      led3_decoded_value});
        end
    endtask

    task automatic test_reset_mid;
        drive(3'b011, 8'h86);
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        drive(3'b111, 8'hFF);
        checks++;
        if ({led1_decoded_value, led2_decoded_value,
             led3_decoded_value, digit_valid} !== 15'h0) begin
            errors++;
            $display("FAIL midreset_clear got %h/%b exp 000/000",
                     {led1_decoded_value, led2_decoded_value,
                      led3_decoded_value}, digit_valid);
        end
        step(6);
        checks++;
        if (digit_valid !== 3'b000 || led1_decoded_value !== 4'h0) begin
            errors++;
            $display("FAIL midreset_pending got %b/%h exp 000/0",
                     digit_valid, led1_decoded_value);
        end
        drive(3'b011, 8'h86);
        step(5);
        checks++;
        if (digit_valid !== 3'b001 || led1_decoded_value !== 4'hE) begin
            errors++;
            $display("FAIL midreset_recover got %b/%h exp 001/e",
                     digit_valid, led1_decoded_value);
        end
    endtask

    initial begin
        test_reset;
        test_digit1;
        test_glitch;
        test_scan;
        test_bad_pattern;
        test_idle;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_display_decoder.md
# seven_segment_display_decoder

Receive-side counterpart of the multiplexed three-digit seven-segment display controller. It watches the segment bus and the three time-multiplexed digit enables, and rejects ghost patterns at digit changeover with a stability filter. It decodes each settled pattern back to a 4-bit hex value and holds one value per digit. It is used for loopback checking of the display path on the board and as a scoreboard front end in simulation.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples of {enables, segments} required before capture; legal range 2..255.
- clk  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- display_bits  input  8  segment bus, active-low; bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
- led1_control_signal, led2_control_signal, led3_control_signal  input  1 each  digit enables, active-low; exactly one low means a valid digit slot.
- led1_decoded_value, led2_decoded_value, led3_decoded_value  output  4 each  last decoded value per digit.
- digit_valid  output  3  bit i set means digit i+1 holds a decoded value from its most recent capture.
- pattern_error  output  1  one-cycle pulse when a settled pattern is neither a hex glyph nor blank.
- frame_done  output  1  one-cycle pulse when digit 3 is captured after digits 1 and 2 have both been captured since the previous pulse.

## Operation
- Input register: {enables, display_bits} sampled every cycle. The dp bit is ignored for decoding but still counts toward stability.
- Stability counter: cleared when the sample differs from the previous sample; otherwise increments and saturates at STABLE_CYCLES.
- FSM states:
  - IDLE: enables are not one-hot-low. Counter is held at 0. Any one-hot-low sample moves to SETTLE.
  - SETTLE: waiting for stability. When the counter reaches STABLE_CYCLES-1 and the sample is unchanged, capture and go to HOLD. A sample change stays in SETTLE with the counter cleared. A non-one-hot enable sample goes to IDLE.
  - HOLD: the captured pattern is stable. A changed sample goes to SETTLE, or to IDLE if the enables are not one-hot. There is no recapture while in HOLD.
- Capture rules, for the selected digit d:
  - Hex glyph: value[d] is set to the decoded nibble and digit_valid[d] is set to 1.
  - Blank (segments 7'h7F, i.e. all off): digit_valid[d] is set to 0, value[d] is unchanged, no error.
  - Any other pattern: digit_valid[d] is set to 0, value[d] is unchanged, pattern_error pulses.
  - In all three cases, captured_mask[d] is set to 1.
- Glyph table, active-high gfedcba before inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- frame_done:
  - Asserts on the capture of digit 3 when captured_mask[1:0]==2'b11.
  - On the same edge, captured_mask is cleared.
  - A digit 3 capture without both earlier digits present clears captured_mask and does not pulse frame_done.
- The same digit can be captured again only after it has left HOLD and settled again.

## Timing
- Reset, on the edge with reset_n low:
  - All decoded values 4'h0, digit_valid 3'b000, pattern_error 0, frame_done 0.
  - FSM in IDLE, counter 0, captured_mask 0.
  - Sample register set to enables 3'b111 and segments 8'hFF.
- Capture latency:
  - With inputs stable from edge t0 onward (first sampled at t0), outputs update at edge t0+STABLE_CYCLES.
  - pattern_error and frame_done are high for exactly the cycle after that edge.
- A change at t0+k with k<STABLE_CYCLES causes no capture; the filter restarts from the new value.
- Reset mid-settle abandons the pending capture and nothing is captured on that edge.
- Simultaneous enable and segment change counts as one change with a single restart.
- The counter cannot wrap: it is 8 bits and saturating.

## Structure
- Package seven_segment_decoder_pkg holds:
  - the glyph table as 16 localparams,
  - the BLANK_PATTERN constant,
  - the enable encodings 3'b011, 3'b101 and 3'b110 for digits 1..3 (the leftmost bit corresponds to digit 1),
  - the state encoding IDLE, SETTLE, HOLD.
- Sub-module seven_segment_pattern_decoder: combinational, 7-bit active-low segments in, {is_glyph, is_blank, value[3:0]} out.
- The parent contains the input register, counter, FSM, per-digit storage and frame tracking.

## Test plan
- Reset, then drive enables 3'b011 with display_bits=8'hC0 held for 4 cycles -> led1_decoded_value=0, digit_valid=3'b001, no pattern_error.
- Drive enables 3'b101 with 8'h80 for 3 cycles, then switch to 8'hF9 for 4 cycles -> no capture of 8; digit 2 = 1, digit_valid[1]=1.
- Scan 3'b011/3'b101/3'b110 with patterns for 3, 7, A, holding each slot 10 cycles -> values 3, 7, A; frame_done pulses once, on the digit 3 capture only.
- Drive enables 3'b110 with 8'hAA (not a glyph) -> pattern_error one-cycle pulse, digit_valid[2]=0, previous value retained; drive 8'hFF -> valid stays 0, no error.
- Drive enables 3'b001 or 3'b111 for 20 cycles -> FSM stays in IDLE, outputs unchanged.
- Assert reset_n=0 for one cycle at cycle 2 of a settle -> all outputs are 0 next cycle and the pending capture never appears.
